alu: RTL and testbench

- Single-cycle RV32I integer ALU for the core's execute stage.
- Computes one of ten register-register operations on two 32-bit operands, selected by funct3 and the funct7 alternate bit.
- Result and zero indicator are registered on the rising clock edge.
- Purely combinational datapath feeding one output register stage; no handshake.

---
 rtl/alu.sv | 82 ++++++++
 tb/tb_alu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Single-cycle RV32I register-register ALU for the execute stage. A purely
//   combinational datapath selects one of ten operations from funct3/funct7.
//   One output register stage follows it, so the result appears one clock
//   after the inputs. There is no handshake: a new result is registered on
//   every rising edge.
//
// Ports
//   clk     in   1     system clock, rising edge
//   rst     in   1     synchronous reset, active-high
//   rs1     in   XLEN  operand A
//   rs2     in   XLEN  operand B; rs2[4:0] is the shift amount for shifts
//   funct3  in   3     operation select (RISC-V encoding)
//   funct7  in   1     alternate-op bit (instruction bit 30): SUB / SRA
//   rd      out  XLEN  registered result
//   z       out  1     registered zero indicator, active-low
//                      (0 when rd is all zeros, 1 otherwise)
// -----------------------------------------------------------------------------
module alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic [XLEN-1:0] rd,
    output logic            z
);

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    logic [XLEN-1:0] rd_d, rd_q;
    logic            z_d, z_q;
    logic [4:0]      shamt;
    logic            lt_s, lt_u;

    assign shamt = rs2[4:0];
    assign lt_s  = $signed(rs1) < $signed(rs2);
    assign lt_u  = rs1 < rs2;

    always_comb begin
        rd_d = '0;
        case (funct3)
            F3_ADD:  rd_d = funct7 ? (rs1 - rs2) : (rs1 + rs2);
            F3_SLL:  rd_d = rs1 << shamt;
            F3_SLT:  rd_d = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: rd_d = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  rd_d = rs1 ^ rs2;
            // Sign fill comes from the signed cast of rs1.
            F3_SR:   rd_d = funct7 ? XLEN'($signed(rs1) >>> shamt) : (rs1 >> shamt);
            F3_OR:   rd_d = rs1 | rs2;
            F3_AND:  rd_d = rs1 & rs2;
            default: rd_d = '0;
        endcase
        // z is taken from the same next value as rd, so the two never disagree.
        z_d = |rd_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            z_q  <= 1'b0;
        end else begin
            rd_q <= rd_d;
            z_q  <= z_d;
        end
    end

    assign rd = rd_q;
    assign z  = z_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] rd;
    logic        z;

    int n_pass = 0;
    int n_total = 0;

    alu #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .z      (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rd;
        logic        exp_z;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        funct3 = f3;
        funct7 = f7;
        rs1    = a;
        rs2    = b;
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 1'b0, 32'd5, 32'd7);

        // Arithmetic
        vecs.push_back('{"add_20_30",     3'b000, 1'b0, 32'd20,         32'd30,  32'd50,         1'b1});
        vecs.push_back('{"sub_8_3",       3'b000, 1'b1, 32'd8,          32'd3,   32'd5,          1'b1});
        vecs.push_back('{"sub_20_20",     3'b000, 1'b1, 32'd20,         32'd20,  32'd0,          1'b0});
        vecs.push_back('{"sub_0_1",       3'b000, 1'b1, 32'd0,          32'd1,   32'hFFFFFFFF,   1'b1});
        vecs.push_back('{"add_wrap",      3'b000, 1'b0, 32'hFFFFFFFF,   32'd1,   32'd0,          1'b0});
        vecs.push_back('{"add_ovf",       3'b000, 1'b0, 32'h7FFFFFFF,   32'd1,   32'h80000000,   1'b1});
        // Shifts
        vecs.push_back('{"sll_8_3",       3'b001, 1'b0, 32'd8,          32'd3,   32'd64,         1'b1});
        vecs.push_back('{"srl_8_3",       3'b101, 1'b0, 32'd8,          32'd3,   32'd1,          1'b1});
        vecs.push_back('{"sra_8_3",       3'b101, 1'b1, 32'd8,          32'd3,   32'd1,          1'b1});
        vecs.push_back('{"sra_neg_4",     3'b101, 1'b1, 32'h80000000,   32'd4,   32'hF8000000,   1'b1});
        vecs.push_back('{"srl_neg_4",     3'b101, 1'b0, 32'h80000000,   32'd4,   32'h08000000,   1'b1});
        vecs.push_back('{"sll_1_x21",     3'b001, 1'b0, 32'd1,          32'h21,  32'd2,          1'b1});
        vecs.push_back('{"sll_f7_31",     3'b001, 1'b1, 32'd1,          32'd31,  32'h80000000,   1'b1});
        vecs.push_back('{"sra_hi_rs2",    3'b101, 1'b1, 32'h80000000,   32'hFFFFFFE1, 32'hC0000000, 1'b1});
        vecs.push_back('{"srl_by0",       3'b101, 1'b0, 32'hA5A5A5A5,   32'h20,  32'hA5A5A5A5,   1'b1});
        vecs.push_back('{"sra_by31",      3'b101, 1'b1, 32'h80000000,   32'd31,  32'hFFFFFFFF,   1'b1});
        // Compares
        vecs.push_back('{"slt_8_3",       3'b010, 1'b0, 32'd8,          32'd3,   32'd0,          1'b0});
        vecs.push_back('{"slt_3_8",       3'b010, 1'b0, 32'd3,          32'd8,   32'd1,          1'b1});
        vecs.push_back('{"slt_m1_1",      3'b010, 1'b0, 32'hFFFFFFFF,   32'd1,   32'd1,          1'b1});
        vecs.push_back('{"sltu_m1_1",     3'b011, 1'b0, 32'hFFFFFFFF,   32'd1,   32'd0,          1'b0});
        vecs.push_back('{"sltu_3_8",      3'b011, 1'b0, 32'd3,          32'd8,   32'd1,          1'b1});
        vecs.push_back('{"slt_eq",        3'b010, 1'b0, 32'd42,         32'd42,  32'd0,          1'b0});
        vecs.push_back('{"sltu_eq",       3'b011, 1'b1, 32'd42,         32'd42,  32'd0,          1'b0});
        vecs.push_back('{"sltu_1_m1_f7",  3'b011, 1'b1, 32'd1,          32'hFFFFFFFF, 32'd1,     1'b1});
        // Logic
        vecs.push_back('{"xor_8_3",       3'b100, 1'b0, 32'd8,          32'd3,   32'd11,         1'b1});
        vecs.push_back('{"or_20_30",      3'b110, 1'b0, 32'd20,         32'd30,  32'd30,         1'b1});
        vecs.push_back('{"and_20_30",     3'b111, 1'b0, 32'd20,         32'd30,  32'd20,         1'b1});
        vecs.push_back('{"and_f0_0f",     3'b111, 1'b0, 32'hF0,         32'h0F,  32'd0,          1'b0});
        vecs.push_back('{"xor_f7",        3'b100, 1'b1, 32'd8,          32'd3,   32'd11,         1'b1});
        vecs.push_back('{"or_f7",         3'b110, 1'b1, 32'd20,         32'd30,  32'd30,         1'b1});
        vecs.push_back('{"and_f7",        3'b111, 1'b1, 32'd20,         32'd30,  32'd20,         1'b1});

        // Reset held for two edges with a nonzero pending ADD
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_rd_%0d", i), rd, 32'd0);
            check($sformatf("rst_z_%0d", i), {31'b0, z}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rd", rd, 32'd12);
        check("post_rst_z", {31'b0, z}, 32'd1);

        // Table-driven vectors, one per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            check({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_z"}, {31'b0, z}, {31'b0, vecs[i].exp_z});
        end

        // Back-to-back ops: before each edge the old result must still be
        // held, after it the new one must be present.
        begin
            logic [2:0]  f3s [4] = '{3'b000, 3'b000, 3'b111, 3'b110};
            logic        f7s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
            logic [31:0] as  [4] = '{32'd1, 32'd10, 32'hFF, 32'h10};
            logic [31:0] bs  [4] = '{32'd2, 32'd4, 32'h0F, 32'h01};
            logic [31:0] es  [4] = '{32'd3, 32'd6, 32'h0F, 32'h11};
            logic [31:0] prev;
            prev = 32'd20; // last table vector: and_f7
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                drive(f3s[i], f7s[i], as[i], bs[i]);
                #1;
                check($sformatf("lat_hold_%0d", i), rd, prev);
                @(posedge clk); #1;
                check($sformatf("lat_new_%0d", i), rd, es[i]);
                prev = es[i];
            end
        end

        // Mid-operation reset discards the pending result
        @(negedge clk);
        drive(3'b000, 1'b0, 32'd100, 32'd23);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rd", rd, 32'd0);
        check("mid_rst_z", {31'b0, z}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_mid_rst_rd", rd, 32'd123);
        check("after_mid_rst_z", {31'b0, z}, 32'd1);

        // Held inputs give a stable output
        @(posedge clk); #1;
        check("hold_stable_rd", rd, 32'd123);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
